// File: rtl/knn_topk_pkg.sv
// knn_topk_pkg: state constants and width helper shared by the knn_topk slice
package knn_topk_pkg;
`include "knn_defs.vh"
    localparam logic [1:0] S_IDLE = `KNN_S_IDLE;
    localparam logic [1:0] S_RUN = `KNN_S_RUN;
    localparam logic [1:0] S_DRAIN = `KNN_S_DRAIN;
    localparam logic [1:0] S_DONE = `KNN_S_DONE;
    function automatic int dist_w(input int dw);
        return `KNN_DIST_W(dw);
    endfunction
endpackage

// File: rtl/knn_defs.vh
// knn_defs: shared FSM encodings and distance-width derivation for knn_topk
`ifndef KNN_DEFS_VH
`define KNN_DEFS_VH
`define KNN_DIST_W(dw) (2*(dw)+2)
`define KNN_S_IDLE 2'd0
`define KNN_S_RUN 2'd1
`define KNN_S_DRAIN 2'd2
`define KNN_S_DONE 2'd3
`endif

// File: rtl/knn_dist.sv
// knn_dist: two enabled pipeline stages computing the exact squared distance
module knn_dist import knn_topk_pkg::*; #(
    parameter int DATA_W = 16,
    parameter int LABEL_W = 8,
    localparam int DIST_W = dist_w(DATA_W)
) (
    input logic clk,
    input logic rst,
    input logic en,
    input logic flush,
    input logic in_vld,
    input logic signed [DATA_W-1:0] in_x,
    input logic signed [DATA_W-1:0] in_y,
    input logic [LABEL_W-1:0] in_label,
    input logic signed [DATA_W-1:0] test_x,
    input logic signed [DATA_W-1:0] test_y,
    output logic s1_vld,
    output logic out_vld,
    output logic [DIST_W-1:0] out_dist,
    output logic [LABEL_W-1:0] out_label
);
    logic signed [DATA_W:0] dx, dy;
    logic signed [DIST_W-1:0] ex, ey;
    logic [LABEL_W-1:0] s1_label;
    // squares are computed at full distance width so the sum can never wrap
    assign ex = DIST_W'(dx);
    assign ey = DIST_W'(dy);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            out_vld <= 1'b0;
            dx <= '0;
            dy <= '0;
            s1_label <= '0;
            out_dist <= '0;
            out_label <= '0;
        end else if (en) begin
            s1_vld <= in_vld && !flush;
            out_vld <= s1_vld && !flush;
            dx <= (DATA_W+1)'(in_x) - (DATA_W+1)'(test_x);
            dy <= (DATA_W+1)'(in_y) - (DATA_W+1)'(test_y);
            s1_label <= in_label;
            out_dist <= $unsigned(ex * ex + ey * ey);
            out_label <= s1_label;
        end
    end
endmodule

// File: rtl/knn_topk.sv
// knn_topk: streaming k-nearest-neighbour selector with a sorted insertion list
module knn_topk import knn_topk_pkg::*; #(
    parameter int DATA_W = 16,
    parameter int K = 4,
    parameter int LABEL_W = 8,
    localparam int DIST_W = dist_w(DATA_W)
) (
    input logic clk,
    input logic rst,
    input logic en,
    input logic start,
    input logic signed [DATA_W-1:0] test_x,
    input logic signed [DATA_W-1:0] test_y,
    input logic pt_valid,
    output logic pt_ready,
    input logic signed [DATA_W-1:0] pt_x,
    input logic signed [DATA_W-1:0] pt_y,
    input logic [LABEL_W-1:0] pt_label,
    input logic pt_last,
    output logic done,
    output logic [K*DIST_W-1:0] nbr_dist,
    output logic [K*LABEL_W-1:0] nbr_label,
    output logic [K-1:0] nbr_vld
);
    logic [1:0] state, nxt;
    logic signed [DATA_W-1:0] tx, ty;
    logic acc, s1_vld, s2_vld;
    logic [DIST_W-1:0] s2_dist;
    logic [LABEL_W-1:0] s2_label;
    logic [K-1:0] le, pre, nv, sv;
    logic [K*DIST_W-1:0] nd, sd;
    logic [K*LABEL_W-1:0] nl, sl;
    assign pt_ready = en && state == S_RUN;
    assign acc = pt_valid && pt_ready && !start;
    assign done = en && state == S_DONE;
    knn_dist #(.DATA_W(DATA_W), .LABEL_W(LABEL_W)) u_dist (
        .clk(clk), .rst(rst), .en(en), .flush(start), .in_vld(acc),
        .in_x(pt_x), .in_y(pt_y), .in_label(pt_label), .test_x(tx), .test_y(ty),
        .s1_vld(s1_vld), .out_vld(s2_vld), .out_dist(s2_dist), .out_label(s2_label)
    );
    // DRAIN ends once stage 1 is empty: the last point is inserted on that same edge
    always_comb nxt = start ? S_RUN :
                      state == S_RUN ? (acc && pt_last ? S_DRAIN : S_RUN) :
                      state == S_DRAIN ? (s1_vld ? S_DRAIN : S_DONE) : S_IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            tx <= '0;
            ty <= '0;
        end else if (en) begin
            state <= nxt;
            if (start) begin
                tx <= test_x;
                ty <= test_y;
            end
        end
    end
    assign sd = nbr_dist << DIST_W;
    assign sl = nbr_label << LABEL_W;
    assign sv = nbr_vld << 1;
    // entries at or below the new distance stay; the first one above takes the new point, the rest shift
    always_comb begin
        le = '0;
        for (int i = 0; i < K; i++) le[i] = nbr_vld[i] && nbr_dist[i*DIST_W +: DIST_W] <= s2_dist;
        pre = (le << 1) | K'(1);
        nd = nbr_dist;
        nl = nbr_label;
        nv = nbr_vld;
        for (int i = 0; i < K; i++) begin
            if (!le[i]) begin
                nd[i*DIST_W +: DIST_W] = pre[i] ? s2_dist : sd[i*DIST_W +: DIST_W];
                nl[i*LABEL_W +: LABEL_W] = pre[i] ? s2_label : sl[i*LABEL_W +: LABEL_W];
                nv[i] = pre[i] || sv[i];
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst || (en && start)) begin
            nbr_vld <= '0;
            nbr_dist <= '1;
            nbr_label <= '0;
        end else if (en && s2_vld) begin
            nbr_vld <= nv;
            nbr_dist <= nd;
            nbr_label <= nl;
        end
    end
endmodule

// File: tb/tb_knn_topk.sv
// tb_knn_topk: directed table-driven checks of knn_topk with DATA_W=16, K=4
`include "knn_defs.vh"
module tb_knn_topk;
    localparam int DW = 16;
    localparam int KK = 4;
    localparam int LW = 8;
    localparam int DSW = `KNN_DIST_W(DW);
    typedef struct packed {
        logic [15:0] tx, ty;
        logic [2:0] n;
        logic [4:0][15:0] px, py;
        logic [4:0][7:0] pl;
        logic [3:0] evld;
        logic [3:0][33:0] ed;
        logic [3:0][7:0] el;
    } vec_t;
    logic clk, rst, en, start, pt_valid, pt_ready, pt_last, done;
    logic signed [DW-1:0] test_x, test_y, pt_x, pt_y;
    logic [LW-1:0] pt_label;
    logic [KK*DSW-1:0] nbr_dist;
    logic [KK*LW-1:0] nbr_label;
    logic [KK-1:0] nbr_vld;
    vec_t vt[5];
    vec_t e;
    int total = 0;
    int bad = 0;
    knn_topk #(.DATA_W(DW), .K(KK), .LABEL_W(LW)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .test_x(test_x), .test_y(test_y),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y),
        .pt_label(pt_label), .pt_last(pt_last), .done(done),
        .nbr_dist(nbr_dist), .nbr_label(nbr_label), .nbr_vld(nbr_vld)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic pulse_start(input int x, input int y);
        start = 1'b1;
        test_x = DW'(x);
        test_y = DW'(y);
        tick();
        start = 1'b0;
    endtask
    task automatic send(input int x, input int y, input int l, input logic last);
        pt_valid = 1'b1;
        pt_x = DW'(x);
        pt_y = DW'(y);
        pt_label = LW'(l);
        pt_last = last;
        tick();
        pt_valid = 1'b0;
        pt_last = 1'b0;
    endtask
    task automatic wait_done(input string nm);
        int first = -1;
        int cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (done) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        chk({nm, " done latency"}, 64'(first), 64'd2);
        chk({nm, " done pulses"}, 64'(cnt), 64'd1);
    endtask
    task automatic check_list(input string nm, input vec_t x);
        chk({nm, " vld"}, 64'(nbr_vld), 64'(x.evld));
        for (int i = 0; i < KK; i++) begin
            chk($sformatf("%s dist%0d", nm, i), 64'(nbr_dist[i*DSW +: DSW]), 64'(x.ed[i]));
            chk($sformatf("%s label%0d", nm, i), 64'(nbr_label[i*LW +: LW]), 64'(x.el[i]));
        end
    endtask
    function automatic void clr(output vec_t x);
        x = '0;
        x.ed = '1;
    endfunction
    function automatic void add_pt(input int v, input int j, input int x, input int y, input int l);
        vt[v].px[j] = 16'(x);
        vt[v].py[j] = 16'(y);
        vt[v].pl[j] = 8'(l);
    endfunction
    function automatic void add_exp(input int v, input int j, input logic [33:0] d, input int l);
        vt[v].ed[j] = d;
        vt[v].el[j] = 8'(l);
    endfunction
    initial begin
        for (int v = 0; v < 5; v++) clr(vt[v]);
        // sorting with a tie: the equal later point loses and falls off the end
        vt[0].n = 5;
        add_pt(0, 0, 3, 4, 1); add_pt(0, 1, 1, 1, 2); add_pt(0, 2, -2, 0, 3);
        add_pt(0, 3, 0, -5, 4); add_pt(0, 4, 1, 0, 5);
        vt[0].evld = 4'b1111;
        add_exp(0, 0, 1, 5); add_exp(0, 1, 2, 2); add_exp(0, 2, 4, 3); add_exp(0, 3, 25, 1);
        vt[1].tx = 16'(10); vt[1].ty = 16'(10); vt[1].n = 2;
        add_pt(1, 0, 10, 12, 7); add_pt(1, 1, 13, 10, 9);
        vt[1].evld = 4'b0011;
        add_exp(1, 0, 4, 7); add_exp(1, 1, 9, 9);
        vt[2].tx = 16'h8000; vt[2].ty = 16'h8000; vt[2].n = 1;
        add_pt(2, 0, 32767, 32767, 8'hAA);
        vt[2].evld = 4'b0001;
        add_exp(2, 0, 34'd8589672450, 8'hAA);
        vt[3].n = 3;
        add_pt(3, 0, 0, 3, 1); add_pt(3, 1, 0, 2, 2); add_pt(3, 2, 0, 1, 3);
        vt[3].evld = 4'b0111;
        add_exp(3, 0, 1, 3); add_exp(3, 1, 4, 2); add_exp(3, 2, 9, 1);
        // equal distances inserted behind existing ties; a full-list tie at the end is discarded
        vt[4].tx = 16'(5); vt[4].ty = 16'hFFFB; vt[4].n = 5;
        add_pt(4, 0, 5, -5, 10); add_pt(4, 1, 5, -5, 11); add_pt(4, 2, 6, -5, 12);
        add_pt(4, 3, 5, -5, 13); add_pt(4, 4, 4, -5, 14);
        vt[4].evld = 4'b1111;
        add_exp(4, 0, 0, 10); add_exp(4, 1, 0, 11); add_exp(4, 2, 0, 13); add_exp(4, 3, 1, 12);
        rst = 1'b1; en = 1'b1; start = 1'b0; test_x = '0; test_y = '0;
        pt_valid = 1'b0; pt_x = '0; pt_y = '0; pt_label = '0; pt_last = 1'b0;
        #12;
        clr(e);
        check_list("reset", e);
        chk("reset done", 64'(done), 64'd0);
        chk("reset ready", 64'(pt_ready), 64'd0);
        rst = 1'b0;
        pt_valid = 1'b1; pt_x = 16'sd1; pt_y = 16'sd1; pt_label = 8'd9; pt_last = 1'b1;
        repeat (4) tick();
        pt_valid = 1'b0; pt_last = 1'b0;
        chk("idle ready", 64'(pt_ready), 64'd0);
        chk("idle vld", 64'(nbr_vld), 64'd0);
        chk("idle done", 64'(done), 64'd0);
        for (int v = 0; v < 5; v++) begin
            pulse_start($signed(vt[v].tx), $signed(vt[v].ty));
            for (int j = 0; j < int'(vt[v].n); j++)
                send($signed(vt[v].px[j]), $signed(vt[v].py[j]), int'(vt[v].pl[j]), j == int'(vt[v].n) - 1);
            wait_done($sformatf("vec%0d", v));
            check_list($sformatf("vec%0d", v), vt[v]);
        end
        // enable low mid-stream with a point offered: nothing moves
        pulse_start(0, 0);
        send(1, 0, 1, 1'b0);
        send(2, 0, 2, 1'b0);
        en = 1'b0;
        pt_valid = 1'b1; pt_x = '0; pt_y = '0; pt_label = 8'd99; pt_last = 1'b1;
        begin
            int rdy = 0;
            int dn = 0;
            repeat (5) begin
                tick();
                rdy += int'(pt_ready);
                dn += int'(done);
            end
            chk("en-low ready", 64'(rdy), 64'd0);
            chk("en-low done", 64'(dn), 64'd0);
            chk("en-low vld", 64'(nbr_vld), 64'd0);
        end
        en = 1'b1;
        send(3, 0, 3, 1'b1);
        wait_done("en-low");
        clr(e);
        e.evld = 4'b0111;
        e.ed[0] = 1; e.el[0] = 1; e.ed[1] = 4; e.el[1] = 2; e.ed[2] = 9; e.el[2] = 3;
        check_list("en-low", e);
        // restart with two points in flight
        pulse_start(0, 0);
        send(1, 0, 1, 1'b0);
        send(2, 0, 2, 1'b0);
        pulse_start(0, 0);
        chk("abort clear", 64'(nbr_vld), 64'd0);
        begin
            int stale = 0;
            int dn = 0;
            repeat (4) begin
                tick();
                stale += int'(nbr_vld != 0);
                dn += int'(done);
            end
            chk("abort stale", 64'(stale), 64'd0);
            chk("abort done", 64'(dn), 64'd0);
        end
        send(0, 7, 20, 1'b1);
        wait_done("abort");
        clr(e);
        e.evld = 4'b0001; e.ed[0] = 49; e.el[0] = 20;
        check_list("abort", e);
        // start and a transfer in the same cycle: the point is dropped
        pulse_start(0, 0);
        start = 1'b1; pt_valid = 1'b1; pt_x = 16'sd1; pt_y = 16'sd1; pt_label = 8'd3;
        tick();
        start = 1'b0; pt_valid = 1'b0;
        chk("same-cycle ready", 64'(pt_ready), 64'd1);
        repeat (3) tick();
        chk("same-cycle vld", 64'(nbr_vld), 64'd0);
        send(0, 2, 4, 1'b1);
        wait_done("same-cycle");
        clr(e);
        e.evld = 4'b0001; e.ed[0] = 4; e.el[0] = 4;
        check_list("same-cycle", e);
        // asynchronous reset mid-run
        pulse_start(0, 0);
        send(1, 0, 1, 1'b0);
        send(2, 0, 2, 1'b1);
        rst = 1'b1;
        #2;
        clr(e);
        check_list("rst-mid", e);
        chk("rst-mid ready", 64'(pt_ready), 64'd0);
        tick();
        rst = 1'b0;
        begin
            int dn = 0;
            repeat (6) begin
                tick();
                dn += int'(done);
            end
            chk("rst-mid done", 64'(dn), 64'd0);
            chk("rst-mid idle", 64'(pt_ready), 64'd0);
            chk("rst-mid vld", 64'(nbr_vld), 64'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
